freq_detect: RTL and testbench

Measures the fundamental frequency of a signed 16-bit audio sample stream and reports it as a 12-bit integer in Hz, the same unit and range used by the synthesiser's oscillator frequency inputs. Sits on the analysis side of the synth. It closes the loop on the sine oscillator output, allowing pitch readback, tuning checks and self-test. Detection uses hysteretic rising-edge crossings; the period is counted in clock cycles and converted to Hz by a serial divider.

---
 rtl/synth_pkg.sv | 19 +
 rtl/udiv_serial.sv | 77 +++++++
 rtl/freq_detect.sv | 115 +++++++++++
 tb/tb_freq_detect.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants and types for the synth analysis blocks: widths, level
// states and the period-to-Hz saturation helper.
package synth_pkg;

  localparam int PERIOD_W = 20;
  localparam int FREQ_W   = 12;
  localparam int DIV_LAT  = 22;

  typedef enum logic [1:0] {
    LVL_UNK  = 2'd0,
    LVL_LOW  = 2'd1,
    LVL_HIGH = 2'd2
  } lvl_e;

  function automatic logic [FREQ_W-1:0] sat_freq(input logic [PERIOD_W-1:0] q);
    return (q > PERIOD_W'((1 << FREQ_W) - 1)) ? {FREQ_W{1'b1}} : q[FREQ_W-1:0];
  endfunction

endpackage

// File: rtl/udiv_serial.sv
// Restoring unsigned divider, one quotient bit per cycle. Start is accepted
// only while idle; done pulses for one cycle with the quotient valid.
module udiv_serial #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  quo_q, quo_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [W:0]    shifted, trial;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, done_q, done_d;

  always_comb begin
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[W-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (busy_q) begin
      // Borrow out of the trial subtraction means the divisor did not fit.
      if (!trial[W]) begin
        rem_d = trial[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = shifted[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      quo_d  = dividend;
      dvs_d  = divisor;
      rem_d  = '0;
      cnt_d  = CW'(W);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/freq_detect.sv
// Pitch readback: hysteretic rising-edge detector, period counter and
// period-to-Hz conversion for the synth analysis path.
//   state     | meaning
//   LVL_UNK   | no level seen since reset
//   LVL_LOW   | last qualifying sample was <= -HYST
//   LVL_HIGH  | last qualifying sample was >= +HYST (LOW->HIGH is an edge)
module freq_detect
  import synth_pkg::*;
#(
  parameter int CLK_HZ     = 1_000_000,
  parameter int HYST       = 256,
  parameter int MAX_PERIOD = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       sample,
  input  logic              sample_en,
  output logic [FREQ_W-1:0] freq,
  output logic              freq_valid,
  output logic              locked
);

  // Start cycle and output register surround the per-bit iterations.
  localparam int DivW = DIV_LAT - 2;
  localparam logic signed [15:0] HystPos = 16'(HYST);
  localparam logic signed [15:0] HystNeg = -HystPos;

  lvl_e                lvl_q, lvl_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic                armed_q, armed_d, lost_q, lost_d;
  logic                locked_q, locked_d, valid_q, valid_d;
  logic                is_high, is_low, edge_ev, at_max, tmo;
  logic                div_start, div_busy, div_done;
  logic [DivW-1:0]     div_quo;

  udiv_serial #(.W(DivW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (DivW'(CLK_HZ)),
    .divisor  (cnt_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_comb begin
    is_high   = $signed(sample) >= HystPos;
    is_low    = $signed(sample) <= HystNeg;
    edge_ev   = sample_en && (lvl_q == LVL_LOW) && is_high;
    at_max    = (cnt_q == PERIOD_W'(MAX_PERIOD));
    tmo       = at_max && !edge_ev && !lost_q;
    // An edge coinciding with the MAX_PERIOD hit only re-arms, like a first edge.
    div_start = edge_ev && armed_q && !at_max && !div_busy;

    lvl_d = lvl_q;
    if (sample_en) begin
      if (is_high)     lvl_d = LVL_HIGH;
      else if (is_low) lvl_d = LVL_LOW;
    end

    cnt_d   = cnt_q;
    armed_d = armed_q;
    lost_d  = lost_q;
    if (edge_ev) begin
      cnt_d   = PERIOD_W'(1);
      armed_d = 1'b1;
      lost_d  = 1'b0;
    end else begin
      if (!at_max) cnt_d = cnt_q + PERIOD_W'(1);
      if (tmo) begin
        armed_d = 1'b0;
        lost_d  = 1'b1;
      end
    end

    valid_d  = div_done || tmo;
    freq_d   = freq_q;
    locked_d = locked_q;
    if (div_done) begin
      freq_d   = sat_freq(div_quo);
      locked_d = 1'b1;
    end
    if (tmo) begin
      freq_d   = '0;
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q    <= LVL_UNK;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      lost_q   <= 1'b0;
      freq_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      lost_q   <= lost_d;
      freq_q   <= freq_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

  assign freq       = freq_q;
  assign freq_valid = valid_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_freq_detect.sv
// Bench for freq_detect: randomized waveforms against an event-time model of
// edges, periods and timeouts; each scenario compares expected/observed pulses.
module tb_freq_detect;

  localparam int CLK_HZ = 1_000_000;
  localparam int HYST   = 256;
  localparam int MAX_P  = 5000;
  localparam int LAT    = 22;
  localparam int SINE_P = 2272;

  logic        clk = 1'b0, rst = 1'b1, sample_en = 1'b0;
  logic [15:0] sample = '0;
  logic [11:0] freq;
  logic        freq_valid, locked;

  freq_detect #(.CLK_HZ(CLK_HZ), .HYST(HYST), .MAX_PERIOD(MAX_P)) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_en(sample_en),
    .freq(freq), .freq_valid(freq_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int f; int lk;} ev_t;
  ev_t exp_q[$], obs_q[$];
  ev_t m_e, o_e;

  int total = 0, bad = 0, dbl = 0, m_cyc = 0, last_hi = 0;
  int sine_tab[SINE_P];
  int m_side, m_base, m_busy_until, m_per, m_s;
  bit m_armed, m_lost, m_edge, prev_v;

  // Reference model: tracks the hysteresis side, the time of the last edge
  // and when the last conversion finishes; predicts every freq_valid pulse.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_side = 0; m_base = m_cyc + 1; m_busy_until = -1; m_armed = 0; m_lost = 0;
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].cyc > m_cyc) exp_q.delete(i);
    end else begin
      m_s    = int'($signed(sample));
      m_edge = sample_en && m_side == 1 && m_s >= HYST;
      if (sample_en && m_s >= HYST) m_side = 2;
      else if (sample_en && m_s <= -HYST) m_side = 1;
      if (m_edge) begin
        m_per = m_cyc - m_base;
        if (m_armed && m_per < MAX_P && m_cyc > m_busy_until) begin
          m_e.cyc = m_cyc + LAT;
          m_e.f   = (CLK_HZ / m_per > 4095) ? 4095 : CLK_HZ / m_per;
          m_e.lk  = 1;
          exp_q.push_back(m_e);
          m_busy_until = m_cyc + 20;
        end
        m_armed = 1; m_lost = 0; m_base = m_cyc;
      end else if (!m_lost && m_cyc - m_base >= MAX_P) begin
        m_e.cyc = m_cyc + 1; m_e.f = 0; m_e.lk = 0;
        exp_q.push_back(m_e);
        m_lost = 1; m_armed = 0;
      end
    end
    m_cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (freq_valid === 1'b1) begin
      o_e.cyc = m_cyc; o_e.f = int'(freq); o_e.lk = int'(locked);
      obs_q.push_back(o_e);
      if (prev_v) dbl++;
    end
    prev_v = (freq_valid === 1'b1);
  end

  task automatic drive(input int s, input bit en);
    sample = 16'(s); sample_en = en;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive(0, 0); drive(0, 0); rst = 1'b0;
    exp_q.delete(); obs_q.delete(); dbl = 0;
  endtask

  task automatic sq(input int hi, input int lo);
    last_hi = m_cyc;
    for (int i = 0; i < hi; i++) drive(8000 - int'($urandom_range(0, 200)), 1);
    for (int i = 0; i < lo; i++) drive(-8000 + int'($urandom_range(0, 200)), 1);
  endtask

  task automatic hold(input int s, input int n);
    for (int i = 0; i < n; i++) drive(s, 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) drive(int'($urandom_range(0, 65535)), 1);
    total++; if (freq !== 12'd0) begin bad++; $display("FAIL reset_freq got=%0d exp=0", freq); end
    total++; if (freq_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", freq_valid); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    rst = 1'b0; exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_sine();
    int amp, ph;
    do_reset();
    amp = int'($urandom_range(1000, 30000));
    ph  = int'($urandom_range(0, SINE_P - 1));
    for (int t = 0; t < 4 * SINE_P; t++) drive(amp * sine_tab[(t + ph) % SINE_P] / 32767, 1);
    hold(0, LAT + 8);
    total++; if (freq !== 12'd440) begin bad++; $display("FAIL sine_freq got=%0d exp=440", freq); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL sine_locked got=%b exp=1", locked); end
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL sine_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].f != exp_q[i].f || obs_q[i].lk != exp_q[i].lk) begin
        bad++;
        $display("FAIL sine_ev%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, obs_q[i].cyc, obs_q[i].f,
                 obs_q[i].lk, exp_q[i].cyc, exp_q[i].f, exp_q[i].lk);
      end
    end
  endtask

  task automatic test_square();
    do_reset();
    hold(-8000, int'($urandom_range(100, 499)));
    for (int i = 0; i < 4; i++) sq(500, 500);
    total++; if (freq !== 12'd1000) begin bad++; $display("FAIL sq1000_freq got=%0d exp=1000", freq); end
    total++;
    if (obs_q.size() == 0 || obs_q[obs_q.size()-1].cyc != last_hi + LAT) begin
      bad++; $display("FAIL sq1000_latency got=%0d exp=%0d", obs_q.size() == 0 ? -1 : obs_q[obs_q.size()-1].cyc, last_hi + LAT);
    end
    for (int i = 0; i < 8; i++) sq(100, 100);
    hold(0, LAT + 8);
    total++; if (freq !== 12'd4095) begin bad++; $display("FAIL sq200_sat got=%0d exp=4095", freq); end
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL square_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].f != exp_q[i].f || obs_q[i].lk != exp_q[i].lk) begin
        bad++;
        $display("FAIL square_ev%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, obs_q[i].cyc, obs_q[i].f,
                 obs_q[i].lk, exp_q[i].cyc, exp_q[i].f, exp_q[i].lk);
      end
    end
  endtask

  task automatic test_hyst();
    int r0, ph;
    do_reset();
    r0 = m_cyc;
    ph = int'($urandom_range(0, SINE_P - 1));
    for (int t = 0; t < MAX_P + 100; t++) drive(200 * sine_tab[(t + ph) % SINE_P] / 32767, 1);
    total++;
    if (obs_q.size() != 1) begin
      bad++; $display("FAIL hyst_count got=%0d exp=1", obs_q.size());
    end else if (obs_q[0].cyc != r0 + MAX_P + 1 || obs_q[0].f != 0 || obs_q[0].lk != 0) begin
      bad++; $display("FAIL hyst_timeout got=%0d/%0d/%0d exp=%0d/0/0", obs_q[0].cyc, obs_q[0].f, obs_q[0].lk, r0 + MAX_P + 1);
    end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL hyst_locked got=%b exp=0", locked); end
  endtask

  task automatic test_drop();
    int e, n0;
    do_reset();
    hold(-8000, 300);
    for (int i = 0; i < 3; i++) sq(500, 500);
    e = last_hi;
    hold(0, MAX_P + 50);
    total++;
    if (obs_q.size() == 0 || obs_q[obs_q.size()-1].cyc != e + MAX_P + 1 || obs_q[obs_q.size()-1].f != 0) begin
      bad++; $display("FAIL drop_timeout got=%0d exp=%0d", obs_q.size() == 0 ? -1 : obs_q[obs_q.size()-1].cyc, e + MAX_P + 1);
    end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL drop_locked got=%b exp=0", locked); end
    n0 = obs_q.size();
    sq(500, 500);
    total++; if (obs_q.size() != n0) begin bad++; $display("FAIL drop_first_edge got=%0d exp=%0d", obs_q.size(), n0); end
    sq(500, 500);
    total++; if (freq !== 12'd1000) begin bad++; $display("FAIL drop_relock got=%0d exp=1000", freq); end
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL drop_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].f != exp_q[i].f || obs_q[i].lk != exp_q[i].lk) begin
        bad++;
        $display("FAIL drop_ev%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, obs_q[i].cyc, obs_q[i].f,
                 obs_q[i].lk, exp_q[i].cyc, exp_q[i].f, exp_q[i].lk);
      end
    end
  endtask

  task automatic test_sparse();
    int ph;
    do_reset();
    ph = int'($urandom_range(0, 999));
    for (int t = 0; t < 5000; t++) begin
      if (t % 4 == 0) drive(((t + ph) % 1000 < 500) ? 8000 : -8000, 1);
      else            drive(int'($urandom_range(0, 65535)) - 32768, 0);
    end
    hold(0, LAT + 8);
    total++; if (freq < 12'd996 || freq > 12'd1004) begin bad++; $display("FAIL sparse_freq got=%0d exp=996..1004", freq); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL sparse_locked got=%b exp=1", locked); end
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL sparse_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].f != exp_q[i].f || obs_q[i].lk != exp_q[i].lk) begin
        bad++;
        $display("FAIL sparse_ev%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, obs_q[i].cyc, obs_q[i].f,
                 obs_q[i].lk, exp_q[i].cyc, exp_q[i].f, exp_q[i].lk);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    hold(-8000, 50);
    for (int i = 0; i < 40; i++) sq(int'($urandom_range(2, 10)), int'($urandom_range(2, 10)));
    for (int i = 0; i < 5; i++) sq(int'($urandom_range(150, 1500)), int'($urandom_range(150, 1500)));
    hold(0, LAT + 8);
    total++; if (dbl != 0) begin bad++; $display("FAIL b2b_double_valid got=%0d exp=0", dbl); end
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].f != exp_q[i].f || obs_q[i].lk != exp_q[i].lk) begin
        bad++;
        $display("FAIL b2b_ev%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, obs_q[i].cyc, obs_q[i].f,
                 obs_q[i].lk, exp_q[i].cyc, exp_q[i].f, exp_q[i].lk);
      end
    end
  endtask

  task automatic test_edge_at_max();
    int e;
    do_reset();
    hold(-8000, 100);
    sq(200, 200);
    e = last_hi;
    while (m_cyc < e + MAX_P) drive(-8000, 1);
    sq(500, 500);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL edgemax_no_pulse got=%0d exp=0", obs_q.size()); end
    sq(500, 500);
    total++;
    if (obs_q.size() != 1 || obs_q[0].f != 1000) begin
      bad++; $display("FAIL edgemax_rearm got=%0d exp=1", obs_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    do_reset();
    hold(-8000, 300);
    for (int i = 0; i < 3; i++) sq(500, 500);
    hold(8000, 10);
    rst = 1'b1; drive(8000, 1); rst = 1'b0;
    total++; if (freq !== 12'd0) begin bad++; $display("FAIL rstmid_freq got=%0d exp=0", freq); end
    total++; if (freq_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", freq_valid); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rstmid_locked got=%b exp=0", locked); end
    n0 = obs_q.size();
    hold(8000, 30);
    total++; if (obs_q.size() != n0) begin bad++; $display("FAIL rstmid_aborted got=%0d exp=%0d", obs_q.size(), n0); end
    hold(-8000, 500);
    sq(500, 500);
    total++; if (obs_q.size() != n0) begin bad++; $display("FAIL rstmid_first_edge got=%0d exp=%0d", obs_q.size(), n0); end
    sq(500, 500);
    hold(0, LAT + 8);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rstmid_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].f != exp_q[i].f || obs_q[i].lk != exp_q[i].lk) begin
        bad++;
        $display("FAIL rstmid_ev%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, obs_q[i].cyc, obs_q[i].f,
                 obs_q[i].lk, exp_q[i].cyc, exp_q[i].f, exp_q[i].lk);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < SINE_P; i++)
      sine_tab[i] = $rtoi(32767.0 * $sin(6.283185307179586 * i / SINE_P));
    test_reset();
    test_sine();
    test_square();
    test_hyst();
    test_drop();
    test_sparse();
    test_back_to_back();
    test_edge_at_max();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
